disp_scan_ctrl: RTL

Time-multiplexed scan controller for a bank of common-anode/cathode seven-segment digits sharing one hex-to-seven-segment decode path. Holds an NDIG-digit hex value, steps through digits at a programmable slot rate with an all-off guard interval between slots, and drives one shared segment bus plus one-hot digit enables. New display values enter through a valid/ready port and are applied only at frame boundaries (tear-free). Sits between the arithmetic/result registers of a lab datapath and the board's multiplexed display pins.

---
 rtl/disp_pkg.sv | 45 ++++
 rtl/disp_scan_ctrl_hex7_lut.sv | 39 +++
 rtl/disp_scan_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared types and constants for the display scan controller:
//                FSM state encoding, segment bit order and hex glyph codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Scan FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_GUARD = 1'b0;
    localparam state_t ST_SHOW  = 1'b1;

    // Segment bus bit order: bit6 = a ... bit0 = g, active-high
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_t;

    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b0011111;
    localparam seg_t SEG_C     = 7'b1001110;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_BLANK = 7'b0000000;

endpackage
`default_nettype wire

// File: rtl/disp_scan_ctrl_hex7_lut.sv
`default_nettype none
// ============================================================================
//  Module      : hex7_lut
//  Description : Combinational hex nibble to active-high abcdefg decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex7_lut
    import disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Glyph lookup; every nibble value maps to a defined code
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_ctrl
//  Description : Time-multiplexed seven-segment scan controller. Steps through
//                NDIG digits with an all-off guard between slots, decodes the
//                committed value through one shared LUT, and accepts new
//                values via valid/ready, committing them only at frame wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int DIV      = 50000,
    parameter int GUARD    = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [4*NDIG-1:0]   load_data,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     an,
    output logic                frame_done
);

    localparam int CMAX = (DIV > GUARD) ? DIV : GUARD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [CW-1:0] C_DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] C_GUARD_LAST = CW'(GUARD - 1);
    localparam logic [SW-1:0] C_SLOT_LAST  = SW'(NDIG - 1);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [SW-1:0]       r_slot;
    logic [4*NDIG-1:0]   r_disp;
    logic [4*NDIG-1:0]   r_shadow;
    logic                r_pending;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [SW-1:0]       w_slot_nxt;
    logic                w_wrap;
    logic [3:0]          w_digits [NDIG];
    logic [NDIG-1:0]     w_blank;
    logic [3:0]          w_hex;
    logic [6:0]          w_lut_seg;
    logic [6:0]          w_seg_nxt;
    logic [NDIG-1:0]     w_an_nxt;

    assign load_ready = ~r_pending;

    // Split the committed value into per-digit nibbles and blank flags.
    // A digit is a leading zero when it and everything above it are zero;
    // digit 0 always shows so an all-zero value still reads "0".
    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        assign w_digits[k] = r_disp[4*k +: 4];
        if (k == 0) begin : g_lsd
            assign w_blank[k] = 1'b0;
        end else begin : g_upper
            assign w_blank[k] = (BLANK_LZ != 0) && (r_disp[4*NDIG-1:4*k] == '0);
        end
    end

    // Scan sequencing: GUARD for GUARD cycles, SHOW for DIV cycles, next slot
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_slot_nxt  = r_slot;
        w_wrap      = 1'b0;
        if (r_state == ST_GUARD) begin
            if (r_cnt == C_GUARD_LAST) begin
                w_state_nxt = ST_SHOW;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (r_cnt == C_DIV_LAST) begin
                w_state_nxt = ST_GUARD;
                w_cnt_nxt   = '0;
                if (r_slot == C_SLOT_LAST) begin
                    w_slot_nxt = '0;
                    w_wrap     = 1'b1;
                end else begin
                    w_slot_nxt = r_slot + 1'b1;
                end
            end
        end
    end

    // Single shared decode path. The slot never changes on an edge that
    // enters or stays in SHOW, so muxing on the current slot is enough.
    assign w_hex = w_digits[r_slot];

    hex7_lut u_lut (
        .hex (w_hex),
        .seg (w_lut_seg)
    );

    // Next registered pin values follow the next FSM state
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        w_an_nxt  = '0;
        if (w_state_nxt == ST_SHOW) begin
            w_an_nxt = NDIG'(1) << r_slot;
            if (!w_blank[r_slot]) begin
                w_seg_nxt = w_lut_seg;
            end
        end
    end

    // State, value storage with tear-free commit, and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_GUARD;
            r_cnt      <= '0;
            r_slot     <= '0;
            r_disp     <= '0;
            r_shadow   <= '0;
            r_pending  <= 1'b0;
            seg        <= SEG_BLANK;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_slot  <= w_slot_nxt;
            if (w_wrap) begin
                // Frame boundary: commit pending value, or take a fresh
                // offer straight through when nothing is waiting
                if (r_pending) begin
                    r_disp    <= r_shadow;
                    r_pending <= 1'b0;
                end else if (load_valid) begin
                    r_disp <= load_data;
                end
            end else if (load_valid && !r_pending) begin
                r_shadow  <= load_data;
                r_pending <= 1'b1;
            end
            seg        <= w_seg_nxt;
            an         <= w_an_nxt;
            frame_done <= w_wrap;
        end
    end

endmodule
`default_nettype wire
